// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the ROB commit unit.
//   - reg_t       : architectural register / pc type
//   - ROB_SIZE    : number of ROB entries, ROB_TAG_W : tag width
//   - KIND_*      : head_kind encodings (3 is reserved and retires as ALU)
//   - state_e     : commit FSM states
package rob_commit_unit_pkg;

  localparam int unsigned REG_WIDTH = 32;
  typedef logic [REG_WIDTH-1:0] reg_t;

  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned ROB_SIZE  = 16;

  localparam logic [1:0] KIND_ALU    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;
  localparam logic [1:0] KIND_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

endpackage

// File: rtl/rob_commit_unit_redirect.sv
// rob_redirect_calc: combinational branch-mispredict detection and
// redirect pc selection for the ROB head.
//   is_branch      : head is a branch
//   pred_taken     : predicted direction
//   real_taken     : resolved direction
//   target_pc      : taken target
//   next_pc        : fall-through pc
//   mispredict     : branch whose directions disagree
//   redirect_pc    : pc to restart fetch from (0 when no mispredict)
module rob_redirect_calc
  import rob_commit_unit_pkg::*;
(
  input  logic is_branch,
  input  logic pred_taken,
  input  logic real_taken,
  input  reg_t target_pc,
  input  reg_t next_pc,
  output logic mispredict,
  output reg_t redirect_pc
);

  // Compare directions and pick the resolved path's pc.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (is_branch && (pred_taken != real_taken)) begin
      mispredict  = 1'b1;
      redirect_pc = real_taken ? target_pc : next_pc;
    end else begin
      mispredict  = 1'b0;
      redirect_pc = '0;
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: retires the ROB head one instruction per cycle.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall when low)
//   head_*                      : ROB head entry description
//   store_done_from_ls_buffer   : committed store reached memory
//   pop_to_ro_buffer            : advance ROB head this cycle
//   commit_*_to_reg_file        : register write-back port
//   reset_from_ro_buffer/pc_from_ro_buffer : mispredict flush + redirect
//   store_from_ro_buffer        : store-release pulse
//   retired_count               : retired instruction counter (wraps)
// Commit outputs are combinational from the head and current state;
// only the FSM state and the counter are registered.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [1:0]           head_kind,
  input  logic [ROB_WIDTH-1:0] head_tag,
  input  logic [4:0]           head_rd,
  input  reg_t                 head_value,
  input  logic                 head_pred_taken,
  input  logic                 head_real_taken,
  input  reg_t                 head_target_pc,
  input  reg_t                 head_next_pc,
  input  logic                 store_done_from_ls_buffer,
  output logic                 pop_to_ro_buffer,
  output logic                 commit_valid_to_reg_file,
  output logic [4:0]           commit_rd_to_reg_file,
  output reg_t                 commit_value_to_reg_file,
  output logic [ROB_WIDTH-1:0] commit_tag_to_reg_file,
  output logic                 reset_from_ro_buffer,
  output reg_t                 pc_from_ro_buffer,
  output logic                 store_from_ro_buffer,
  output logic [CNT_WIDTH-1:0] retired_count
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic is_branch;
  logic mispredict;
  reg_t redirect_pc;

  assign is_branch = (head_kind == KIND_BRANCH);

  rob_redirect_calc u_redirect (
    .is_branch  (is_branch),
    .pred_taken (head_pred_taken),
    .real_taken (head_real_taken),
    .target_pc  (head_target_pc),
    .next_pc    (head_next_pc),
    .mispredict (mispredict),
    .redirect_pc(redirect_pc)
  );

  // Next-state, commit outputs and counter update.
  always_comb begin
    state_d                  = state_q;
    count_d                  = count_q;
    pop_to_ro_buffer         = 1'b0;
    commit_valid_to_reg_file = 1'b0;
    commit_rd_to_reg_file    = 5'd0;
    commit_value_to_reg_file = '0;
    commit_tag_to_reg_file   = '0;
    reset_from_ro_buffer     = 1'b0;
    pc_from_ro_buffer        = '0;
    store_from_ro_buffer     = 1'b0;

    if (rst_in) begin
      // Abandon any pending store/flush; nothing is popped.
      state_d = ST_IDLE;
      count_d = '0;
    end else if (!rdy_in) begin
      // Frozen: hold state, emit nothing, drop any store_done seen now.
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (head_valid && head_ready) begin
            if (head_kind == KIND_STORE) begin
              store_from_ro_buffer = 1'b1;
              state_d              = ST_STORE_WAIT;
            end else begin
              // ALU, BRANCH and the reserved kind all retire the same way.
              pop_to_ro_buffer         = 1'b1;
              commit_valid_to_reg_file = (head_rd != 5'd0);
              commit_rd_to_reg_file    = head_rd;
              commit_value_to_reg_file = head_value;
              commit_tag_to_reg_file   = head_tag;
              if (mispredict) begin
                reset_from_ro_buffer = 1'b1;
                pc_from_ro_buffer    = redirect_pc;
                state_d              = ST_FLUSH;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_STORE_WAIT: begin
          if (store_done_from_ls_buffer) begin
            pop_to_ro_buffer = 1'b1;
            state_d          = ST_IDLE;
          end else begin
            state_d = ST_STORE_WAIT;
          end
        end
        ST_FLUSH: begin
          // One dead cycle while the pipeline drains; head is ignored.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (pop_to_ro_buffer) begin
        count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_q;
      end
    end
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (pending-store flag, flush flag, retire counter).
module tb_rob_commit_unit;

  localparam int CW = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        head_valid = 1'b0;
  logic        head_ready = 1'b0;
  logic [1:0]  head_kind = 2'd0;
  logic [3:0]  head_tag = 4'd0;
  logic [4:0]  head_rd = 5'd0;
  logic [31:0] head_value = 32'd0;
  logic        head_pred_taken = 1'b0;
  logic        head_real_taken = 1'b0;
  logic [31:0] head_target_pc = 32'd0;
  logic [31:0] head_next_pc = 32'd0;
  logic        store_done = 1'b0;

  logic          pop, cvalid, rst_pulse, st_pulse;
  logic [4:0]    crd;
  logic [31:0]   cval, rpc;
  logic [3:0]    ctag;
  logic [CW-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  // model state
  bit m_wait = 1'b0;
  bit m_flush = 1'b0;
  int m_cnt = 0;

  rob_commit_unit #(.ROB_WIDTH(4), .CNT_WIDTH(CW)) dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .rdy_in                   (rdy_in),
    .head_valid               (head_valid),
    .head_ready               (head_ready),
    .head_kind                (head_kind),
    .head_tag                 (head_tag),
    .head_rd                  (head_rd),
    .head_value               (head_value),
    .head_pred_taken          (head_pred_taken),
    .head_real_taken          (head_real_taken),
    .head_target_pc           (head_target_pc),
    .head_next_pc             (head_next_pc),
    .store_done_from_ls_buffer(store_done),
    .pop_to_ro_buffer         (pop),
    .commit_valid_to_reg_file (cvalid),
    .commit_rd_to_reg_file    (crd),
    .commit_value_to_reg_file (cval),
    .commit_tag_to_reg_file   (ctag),
    .reset_from_ro_buffer     (rst_pulse),
    .pc_from_ro_buffer        (rpc),
    .store_from_ro_buffer     (st_pulse),
    .retired_count            (cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural reference: evaluated mid-cycle while inputs are stable,
  // then the model advances to what the next rising edge should produce.
  always @(negedge clk_in) begin
    bit          e_pop, e_cv, e_rst, e_st;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_pc;
    logic [3:0]  e_tag;
    e_pop = 0; e_cv = 0; e_rst = 0; e_st = 0;
    e_rd = 5'd0; e_val = 32'd0; e_pc = 32'd0; e_tag = 4'd0;
    if (model_on) begin
      chk("count", {28'd0, cnt}, m_cnt);
      if (rst_in) begin
        m_wait = 0; m_flush = 0; m_cnt = 0;
      end else if (!rdy_in) begin
        m_cnt = m_cnt;
      end else if (m_flush) begin
        m_flush = 0;
      end else if (m_wait) begin
        if (store_done) begin
          e_pop = 1; m_wait = 0;
        end
      end else if (head_valid && head_ready) begin
        if (head_kind == 2'd2) begin
          e_st = 1; m_wait = 1;
        end else begin
          e_pop = 1;
          e_cv  = (head_rd != 5'd0);
          e_rd = head_rd; e_val = head_value; e_tag = head_tag;
          if (head_kind == 2'd1 && head_pred_taken != head_real_taken) begin
            e_rst = 1; m_flush = 1;
            e_pc = head_real_taken ? head_target_pc : head_next_pc;
          end
        end
      end
      chk("pop", {31'd0, pop}, {31'd0, e_pop});
      chk("commit_valid", {31'd0, cvalid}, {31'd0, e_cv});
      chk("flush", {31'd0, rst_pulse}, {31'd0, e_rst});
      chk("redirect_pc", rpc, e_pc);
      chk("store", {31'd0, st_pulse}, {31'd0, e_st});
      if (e_cv) begin
        chk("commit_rd", {27'd0, crd}, {27'd0, e_rd});
        chk("commit_value", cval, e_val);
        chk("commit_tag", {28'd0, ctag}, {28'd0, e_tag});
      end
      if (e_pop) m_cnt = (m_cnt + 1) % (1 << CW);
    end
  end

  task automatic to_check;
    @(negedge clk_in); #1;
  endtask

  task automatic to_drive;
    @(posedge clk_in); #1;
  endtask

  task automatic set_head(input bit v, input logic [1:0] k, input logic [4:0] rd,
                          input logic [31:0] val, input logic [3:0] tag);
    head_valid = v; head_ready = v; head_kind = k;
    head_rd = rd; head_value = val; head_tag = tag;
  endtask

  initial begin
    logic [CW-1:0] c0;
    to_drive; to_drive;
    model_on = 1'b1;
    to_check;
    chk("lit_reset_pop", {31'd0, pop}, 32'd0);
    to_drive;
    rst_in = 1'b0;
    to_check;
    chk("lit_reset_count", {28'd0, cnt}, 32'd0);

    // ALU rd=5 value=0x1234 tag=3
    to_drive; set_head(1, 2'd0, 5'd5, 32'h1234, 4'd3);
    to_check;
    chk("lit_alu_pop", {31'd0, pop}, 32'd1);
    chk("lit_alu_rd", {27'd0, crd}, 32'd5);
    chk("lit_alu_val", cval, 32'h1234);
    chk("lit_alu_tag", {28'd0, ctag}, 32'd3);
    chk("lit_alu_cnt0", {28'd0, cnt}, 32'd0);
    // ALU rd=0
    to_drive; set_head(1, 2'd0, 5'd0, 32'h55, 4'd4);
    to_check;
    chk("lit_alu_cnt1", {28'd0, cnt}, 32'd1);
    chk("lit_rd0_cv", {31'd0, cvalid}, 32'd0);
    chk("lit_rd0_pop", {31'd0, pop}, 32'd1);
    // mispredicted branch
    to_drive; set_head(1, 2'd1, 5'd1, 32'h88, 4'd5);
    head_pred_taken = 1'b0; head_real_taken = 1'b1;
    head_target_pc = 32'h100; head_next_pc = 32'h84;
    to_check;
    chk("lit_br_reset", {31'd0, rst_pulse}, 32'd1);
    chk("lit_br_pc", rpc, 32'h100);
    chk("lit_br_pop", {31'd0, pop}, 32'd1);
    to_drive;
    to_check;
    chk("lit_flush_pop", {31'd0, pop}, 32'd0);
    chk("lit_flush_reset", {31'd0, rst_pulse}, 32'd0);
    chk("lit_flush_cnt", {28'd0, cnt}, 32'd3);
    head_real_taken = 1'b0;
    // store with store_done held off
    to_drive; set_head(1, 2'd2, 5'd0, 32'h0, 4'd6);
    to_check;
    chk("lit_st_pulse", {31'd0, st_pulse}, 32'd1);
    chk("lit_st_pop", {31'd0, pop}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      to_drive; to_check;
      chk("lit_stw_pulse", {31'd0, st_pulse}, 32'd0);
      chk("lit_stw_pop", {31'd0, pop}, 32'd0);
    end
    to_drive; store_done = 1'b1;
    to_check;
    chk("lit_std_pop", {31'd0, pop}, 32'd1);
    chk("lit_std_cv", {31'd0, cvalid}, 32'd0);
    to_drive; store_done = 1'b0; set_head(0, 2'd0, 5'd0, 32'h0, 4'd0);
    to_check;
    chk("lit_std_cnt", {28'd0, cnt}, 32'd4);
    // reset during STORE_WAIT
    to_drive; set_head(1, 2'd2, 5'd0, 32'h0, 4'd7);
    to_drive; set_head(0, 2'd0, 5'd0, 32'h0, 4'd0);
    rst_in = 1'b1; store_done = 1'b1;
    to_check;
    chk("lit_rst_pop", {31'd0, pop}, 32'd0);
    to_drive; rst_in = 1'b0;
    to_check;
    chk("lit_rst_pop2", {31'd0, pop}, 32'd0);
    chk("lit_rst_cnt", {28'd0, cnt}, 32'd0);
    to_drive; store_done = 1'b0;
    // rdy_in low with a ready head
    set_head(1, 2'd0, 5'd9, 32'h77, 4'd1); rdy_in = 1'b0;
    to_check;
    chk("lit_rdy_pop", {31'd0, pop}, 32'd0);
    to_drive; to_check;
    chk("lit_rdy_cnt", {28'd0, cnt}, 32'd0);
    // 16 commits wrap the 4-bit counter back to its start value
    to_drive; rdy_in = 1'b1;
    c0 = cnt;
    for (int i = 0; i < 16; i++) to_drive;
    set_head(0, 2'd0, 5'd0, 32'h0, 4'd0);
    to_check;
    chk("lit_wrap", {28'd0, cnt}, {28'd0, c0});

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      to_drive;
      rst_in          = ($urandom_range(0, 99) < 2);
      rdy_in          = ($urandom_range(0, 99) < 88);
      head_valid      = ($urandom_range(0, 99) < 80);
      head_ready      = ($urandom_range(0, 99) < 80);
      head_kind       = 2'($urandom_range(0, 3));
      head_tag        = 4'($urandom);
      head_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      head_value      = $urandom;
      head_pred_taken = 1'($urandom);
      head_real_taken = 1'($urandom);
      head_target_pc  = $urandom;
      head_next_pc    = $urandom;
      store_done      = ($urandom_range(0, 99) < 30);
    end
    to_drive;
    to_check;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 The module SHALL have parameter ROB_WIDTH, default 4, giving the ROB tag width (16 entries).
REQ-002 The module SHALL have parameter CNT_WIDTH, default 32, giving the retired-instruction counter width.
REQ-003 clk_in  input  1  clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 rdy_in  input  1  global ready; low freezes all state and forces pulse outputs to 0.
REQ-006 head_valid  input  1  ROB head entry exists.
REQ-007 head_ready  input  1  head result written back.
REQ-008 head_kind  input  2  head class: 0 ALU, 1 BRANCH, 2 STORE, 3 reserved (treated as ALU).
REQ-009 head_tag  input  ROB_WIDTH  head entry tag.
REQ-010 head_rd  input  5  destination register; 0 means no write.
REQ-011 head_value  input  `REG_TYPE  result value.
REQ-012 head_pred_taken, head_real_taken  input  1 each  predicted and resolved branch direction.
REQ-013 head_target_pc, head_next_pc  input  `REG_TYPE each  taken target and fall-through pc.
REQ-014 store_done_from_ls_buffer  input  1  committed store has reached memory.
REQ-015 pop_to_ro_buffer  output  1  advance the ROB head this cycle.
REQ-016 commit_valid_to_reg_file, commit_rd_to_reg_file (5), commit_value_to_reg_file (`REG_TYPE), commit_tag_to_reg_file (ROB_WIDTH)  output  register write-back port.
REQ-017 reset_from_ro_buffer  output  1  flush pulse to the rob_bus.
REQ-018 pc_from_ro_buffer  output  `REG_TYPE  redirect pc to the rob_bus.
REQ-019 store_from_ro_buffer  output  1  store-release pulse to the rob_bus.
REQ-020 retired_count  output  CNT_WIDTH  number of retired instructions.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, STORE_WAIT and FLUSH.
REQ-022 In IDLE, with head_valid, head_ready and ALU kind: same cycle, pop=1; commit_valid=1 if head_rd!=0; rd/value/tag driven from the head; state stays IDLE.
REQ-023 BRANCH with head_pred_taken==head_real_taken: retire exactly as ALU (jal/jalr write rd).
REQ-024 BRANCH with direction mismatch: retire as ALU, and in the same cycle reset_from_ro_buffer=1 and pc_from_ro_buffer = head_real_taken ? head_target_pc : head_next_pc; next state FLUSH.
REQ-025 STORE: store_from_ro_buffer=1 for exactly one cycle, pop=0, next state STORE_WAIT.
REQ-026 In STORE_WAIT, store_done=1 SHALL give pop=1 in the same cycle, with no register write and a return to IDLE; otherwise the state holds, all pulses stay 0 and the head is ignored.
REQ-027 In FLUSH, all outputs other than retired_count SHALL be 0 and the head SHALL be ignored; the state returns to IDLE after one cycle.
REQ-028 Commit is combinational from head inputs plus state (0 cycles latency); state and counter are registered.
REQ-029 pc_from_ro_buffer SHALL be 0 whenever reset_from_ro_buffer is 0.
REQ-030 Limits: at most one retirement per cycle; reset and store pulses are never asserted together.
REQ-031 retired_count SHALL increment once per pop and wrap modulo 2^CNT_WIDTH.
REQ-032 With head_valid=0 or head_ready=0 in IDLE, all pulses SHALL be 0.
REQ-033 store_done outside STORE_WAIT SHALL be ignored.
REQ-034 With rdy_in=0, no pulse is output and no state or counter changes; a pending STORE_WAIT persists, and store_done seen while rdy_in=0 is lost (ls_buffer holds it).

Reset
REQ-035 rst_in=1 SHALL, at the next edge, force state=IDLE and retired_count=0.
REQ-036 While rst_in=1, all pulse and commit outputs SHALL be 0 and pc_from_ro_buffer SHALL be 0.
REQ-037 rst_in SHALL take priority over rdy_in.
REQ-038 Reset during STORE_WAIT or FLUSH SHALL abandon the operation without issuing a pop.

Structure
REQ-039 `REG_TYPE, ROB size and tag width, and the head_kind encodings (KIND_ALU/BRANCH/STORE) SHALL live in config.v.
REQ-040 FSM state encodings SHALL be local parameters.
REQ-041 There SHALL be one natural sub-module, rob_redirect_calc: the mispredict compare and redirect-pc select (combinational).
REQ-042 The outputs SHALL connect directly to the existing rob_bus inputs.

Verification
REQ-043 ALU head (rd=5, value=0x1234, tag=3) ready -> same cycle pop=1, commit rd=5 value=0x1234 tag=3; retired_count 0->1.
REQ-044 ALU head with rd=0 -> pop=1, commit_valid=0, count increments.
REQ-045 Branch pred=0, real=1, target=0x100, next=0x84 -> reset=1, pc=0x100, pop=1; next cycle FLUSH with all pulses 0; then IDLE.
REQ-046 Store head -> store pulse for 1 cycle; store_done held off 5 cycles -> pop=0 throughout; store_done -> pop=1, commit_valid=0, count +1.
REQ-047 rst_in asserted in STORE_WAIT, then store_done -> no pop; state IDLE; count 0.
REQ-048 Counter preloaded to 2^CNT_WIDTH-1 (or CNT_WIDTH=4 with 16 commits) -> wraps to 0; and rdy_in=0 with a ready head -> no pop and count unchanged.
